// File: rtl/gpr_seq_ctrl.sv
// Sequencer and 1-bit serial ALU for the two-entry bit-serial GPR file.
// One register-immediate operation is streamed LSB first through the GPR over WIDTH cycles.
`timescale 1ns/1ps

module gpr_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic             i_addr,
    input  logic [WIDTH-1:0] i_imm,
    input  logic             i_gpr_bit,
    output logic             o_gpr_shift,
    output logic             o_gpr_write,
    output logic             o_gpr_addr,
    output logic             o_gpr_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_carry,
    output logic             o_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_CLR  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_NOT  = 3'b111
    } op_t;

    state_t           state;
    op_t              op_q;
    op_t              new_op;
    logic [WIDTH-1:0] imm_q;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic             zero_acc;
    logic             res_bit;
    logic             carry_next;
    logic             last_bit;
    logic             bit_a;
    logic             bit_b;

    assign new_op   = op_t'(i_op);
    assign bit_a    = i_gpr_bit;
    // imm_q is shifted right every EXEC cycle, so bit 0 is always imm[k].
    assign bit_b    = imm_q[0];
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        res_bit    = 1'b0;
        carry_next = carry_q;
        case (op_q)
            OP_CLR:  res_bit = 1'b0;
            OP_LOAD: res_bit = bit_b;
            OP_ADD: begin
                res_bit    = bit_a ^ bit_b ^ carry_q;
                carry_next = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
            end
            OP_SUB: begin
                res_bit    = bit_a ^ ~bit_b ^ carry_q;
                carry_next = (bit_a & ~bit_b) | (bit_a & carry_q) | (~bit_b & carry_q);
            end
            OP_AND:  res_bit = bit_a & bit_b;
            OP_OR:   res_bit = bit_a | bit_b;
            OP_XOR:  res_bit = bit_a ^ bit_b;
            OP_NOT:  res_bit = ~bit_a;
            default: res_bit = 1'b0;
        endcase
    end

    assign o_gpr_data = res_bit;

    // Flags update only on the EXEC->DONE edge and survive later accepts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            op_q        <= OP_CLR;
            imm_q       <= '0;
            cnt         <= '0;
            carry_q     <= 1'b0;
            zero_acc    <= 1'b0;
            o_ready     <= 1'b1;
            o_gpr_shift <= 1'b0;
            o_gpr_write <= 1'b0;
            o_gpr_addr  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_carry     <= 1'b0;
            o_zero      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        state       <= ST_EXEC;
                        op_q        <= new_op;
                        imm_q       <= i_imm;
                        cnt         <= '0;
                        carry_q     <= (new_op == OP_SUB);
                        zero_acc    <= 1'b0;
                        o_ready     <= 1'b0;
                        o_gpr_shift <= 1'b1;
                        o_gpr_write <= (new_op != OP_CLR);
                        o_gpr_addr  <= i_addr;
                        o_busy      <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    carry_q  <= carry_next;
                    zero_acc <= zero_acc | res_bit;
                    imm_q    <= imm_q >> 1;
                    cnt      <= cnt + 1'b1;
                    if (last_bit) begin
                        state       <= ST_DONE;
                        o_gpr_shift <= 1'b0;
                        o_gpr_write <= 1'b0;
                        o_carry     <= carry_next;
                        o_zero      <= ~(zero_acc | res_bit);
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    o_busy  <= 1'b0;
                    o_ready <= 1'b1;
                    o_done  <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    o_ready     <= 1'b1;
                    o_busy      <= 1'b0;
                    o_gpr_shift <= 1'b0;
                    o_gpr_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_seq_ctrl.sv
// Directed bench for gpr_seq_ctrl with a behavioural two-entry bit-serial GPR attached.
`timescale 1ns/1ps

module tb_gpr_seq_ctrl;

    localparam int W = 8;
    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic         addr  = 1'b0;
    logic [W-1:0] imm   = '0;
    logic         gpr_bit;
    logic         o_ready, gpr_shift, gpr_write, gpr_addr, gpr_data;
    logic         o_busy, o_done, o_carry, o_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] gpr [2] = '{8'h00, 8'h00};

    gpr_seq_ctrl #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid),
        .o_ready     (o_ready),
        .i_op        (op),
        .i_addr      (addr),
        .i_imm       (imm),
        .i_gpr_bit   (gpr_bit),
        .o_gpr_shift (gpr_shift),
        .o_gpr_write (gpr_write),
        .o_gpr_addr  (gpr_addr),
        .o_gpr_data  (gpr_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_carry     (o_carry),
        .o_zero      (o_zero)
    );

    always #5 clk = ~clk;

    // GPR: shift right, insert at MSB (zero when write is low), bit 0 feeds back.
    assign gpr_bit = gpr[gpr_addr][0];
    always @(posedge clk) begin
        if (gpr_shift)
            gpr[gpr_addr] <= {gpr_write ? gpr_data : 1'b0, gpr[gpr_addr][W-1:1]};
    end

    task automatic run_op(input logic [2:0] o, input logic a, input logic [W-1:0] v,
                          output int lat, output int n_shift, output int n_write,
                          output logic ready_low);
        @(negedge clk);
        valid = 1'b1; op = o; addr = a; imm = v;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; op = ~o; addr = ~a; imm = ~v;
        ready_low = !o_ready;
        lat = -1; n_shift = 0; n_write = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_done) begin
                lat = c;
                break;
            end
            if (gpr_shift) n_shift++;
            if (gpr_write) n_write++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({gpr_shift, gpr_write, gpr_addr, o_busy, o_done, o_carry, o_zero} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000000",
                     {gpr_shift, gpr_write, gpr_addr, o_busy, o_done, o_carry, o_zero});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b expected 1", o_ready);
        end
    endtask

    task automatic test_load();
        int lat, ns, nw;
        logic rl;
        run_op(OP_LOAD, 1'b1, 8'hA5, lat, ns, nw, rl);
        tests_run++;
        if (rl !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_ready_drop: got ready_low=%b expected 1", rl);
        end
        tests_run++;
        if (lat != 9) begin
            tests_failed++;
            $display("[TB] FAIL load_latency: got %0d expected 9", lat);
        end
        tests_run++;
        if (ns != 8 || nw != 8) begin
            tests_failed++;
            $display("[TB] FAIL load_shift_write: got shift=%0d write=%0d expected 8/8", ns, nw);
        end
        tests_run++;
        if (gpr[1] !== 8'hA5 || gpr[0] !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL load_regs: got rx=%h ry=%h expected a5/00", gpr[1], gpr[0]);
        end
        tests_run++;
        if (o_zero !== 1'b0 || o_carry !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_flags: got z=%b c=%b expected 0/0", o_zero, o_carry);
        end
    endtask

    task automatic test_add();
        int lat, ns, nw;
        logic rl;
        run_op(OP_LOAD, 1'b1, 8'hF0, lat, ns, nw, rl);
        run_op(OP_ADD, 1'b1, 8'h20, lat, ns, nw, rl);
        tests_run++;
        if (lat != 9 || gpr[1] !== 8'h10 || o_carry !== 1'b1 || o_zero !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL add_carry: got lat=%0d rx=%h c=%b z=%b expected 9/10/1/0",
                     lat, gpr[1], o_carry, o_zero);
        end
        run_op(OP_ADD, 1'b1, 8'h01, lat, ns, nw, rl);
        tests_run++;
        if (gpr[1] !== 8'h11 || o_carry !== 1'b0 || o_zero !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL add_nocarry: got rx=%h c=%b z=%b expected 11/0/0",
                     gpr[1], o_carry, o_zero);
        end
    endtask

    task automatic test_sub();
        int lat, ns, nw;
        logic rl;
        run_op(OP_LOAD, 1'b0, 8'h05, lat, ns, nw, rl);
        run_op(OP_SUB, 1'b0, 8'h05, lat, ns, nw, rl);
        tests_run++;
        if (gpr[0] !== 8'h00 || o_carry !== 1'b1 || o_zero !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sub_zero: got ry=%h c=%b z=%b expected 00/1/1",
                     gpr[0], o_carry, o_zero);
        end
        run_op(OP_SUB, 1'b0, 8'h01, lat, ns, nw, rl);
        tests_run++;
        if (gpr[0] !== 8'hFF || o_carry !== 1'b0 || o_zero !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sub_borrow: got ry=%h c=%b z=%b expected ff/0/0",
                     gpr[0], o_carry, o_zero);
        end
    endtask

    task automatic test_logic();
        int lat, ns, nw;
        logic rl;
        logic [W-1:0] rx_before;
        logic [2:0]   ops  [5] = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_CLR};
        logic [W-1:0] imms [5] = '{8'h0F, 8'hC0, 8'hFF, 8'h55, 8'hAA};
        logic [W-1:0] exps [5] = '{8'h0C, 8'hCC, 8'h33, 8'hCC, 8'h00};
        run_op(OP_LOAD, 1'b0, 8'h3C, lat, ns, nw, rl);
        rx_before = gpr[1];
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], 1'b0, imms[i], lat, ns, nw, rl);
            tests_run++;
            if (gpr[0] !== exps[i] || o_carry !== 1'b0 || o_zero !== (exps[i] == 8'h00)) begin
                tests_failed++;
                $display("[TB] FAIL logic_op%0d: got ry=%h c=%b z=%b expected %h/0/%b",
                         i, gpr[0], o_carry, o_zero, exps[i], exps[i] == 8'h00);
            end
        end
        tests_run++;
        if (nw != 0 || ns != 8) begin
            tests_failed++;
            $display("[TB] FAIL clr_write: got write=%0d shift=%0d expected 0/8", nw, ns);
        end
        tests_run++;
        if (gpr[1] !== rx_before) begin
            tests_failed++;
            $display("[TB] FAIL logic_rx_kept: got %h expected %h", gpr[1], rx_before);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q [$];
        int last_acc = -1;
        int n_acc = 0;
        logic got_done = 1'b0;
        for (int n = 0; n < 31; n++) begin
            @(negedge clk);
            valid = 1'b1; op = OP_LOAD; addr = 1'b0; imm = 8'h30 + 8'(n);
            if (o_done) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_spurious_done: got done at %0d expected none", n);
                end else if (gpr[0] !== exp_q[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_value: got ry=%h expected %h", gpr[0], exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (o_ready) begin
                if (last_acc >= 0) begin
                    tests_run++;
                    if (n - last_acc != 10) begin
                        tests_failed++;
                        $display("[TB] FAIL b2b_interval: got %0d expected 10", n - last_acc);
                    end
                end
                last_acc = n;
                n_acc++;
                exp_q.push_back(imm);
            end
        end
        @(negedge clk);
        valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (o_done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (n_acc != 4 || !got_done || gpr[0] !== 8'h4E) begin
            tests_failed++;
            $display("[TB] FAIL b2b_final: got accepts=%0d done=%b ry=%h expected 4/1/4e",
                     n_acc, got_done, gpr[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat, ns, nw;
        logic rl;
        logic saw_done = 1'b0;
        run_op(OP_LOAD, 1'b1, 8'hFF, lat, ns, nw, rl);
        run_op(OP_ADD, 1'b1, 8'h01, lat, ns, nw, rl);
        tests_run++;
        if (gpr[1] !== 8'h00 || o_carry !== 1'b1 || o_zero !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_add: got rx=%h c=%b z=%b expected 00/1/1",
                     gpr[1], o_carry, o_zero);
        end
        @(negedge clk);
        valid = 1'b1; op = OP_ADD; addr = 1'b1; imm = 8'h01;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (o_busy !== 1'b1 || gpr_shift !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_busy: got busy=%b shift=%b expected 1/1", o_busy, gpr_shift);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({gpr_shift, gpr_write, gpr_addr, o_busy, o_done, o_carry, o_zero} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: got %b expected 0000000",
                     {gpr_shift, gpr_write, gpr_addr, o_busy, o_done, o_carry, o_zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_ready: got %b expected 1", o_ready);
        end
        repeat (12) begin
            @(negedge clk);
            if (o_done) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_no_done: got done=%b expected 0", saw_done);
        end
        run_op(OP_LOAD, 1'b1, 8'h5A, lat, ns, nw, rl);
        tests_run++;
        if (lat != 9 || gpr[1] !== 8'h5A || o_zero !== 1'b0 || o_carry !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reload: got lat=%0d rx=%h z=%b c=%b expected 9/5a/0/0",
                     lat, gpr[1], o_zero, o_carry);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_sub();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gpr_seq_ctrl.md
Name: gpr_seq_ctrl

Overview:
- Sequencer and 1-bit serial ALU for the two-entry bit-serial GPR file (ry at address 0, rx at address 1).
- Accepts one register-immediate operation per handshake and drives the GPR's shift, write, address and serial-data lines for WIDTH cycles.
- Each bit is read-modified-written LSB first. Carry and zero flags are produced for the rest of the datapath.
- Sits between instruction decode (upstream) and the gpr instance (downstream).

Parameters:
- WIDTH, 8, register width in bits. Must equal the GPR width and be ≥2. Bit counter width is clog2(WIDTH).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  operation request.
- o_ready  out  1  controller can accept a request (high only in IDLE).
- i_op  in  3  operation code (see Behaviour).
- i_addr  in  1  target register: 0 = ry, 1 = rx.
- i_imm  in  WIDTH  immediate operand.
- i_gpr_bit  in  1  GPR serial output (bit 0 of the selected register).
- o_gpr_shift  out  1  to GPR i_con_shift.
- o_gpr_write  out  1  to GPR i_con_write.
- o_gpr_addr  out  1  to GPR rd_addr.
- o_gpr_data  out  1  to GPR i_data_in.
- o_busy  out  1  high in EXEC and DONE.
- o_done  out  1  one-cycle completion pulse.
- o_carry  out  1  carry flag of the last completed op.
- o_zero  out  1  result-is-zero flag of the last completed op.

Behaviour:
- Reset (asynchronous on i_rst_n low) forces:
  - state = IDLE, counter = 0, carry reg = 0, zero-accumulator = 0;
  - o_ready = 1 once reset is released;
  - o_gpr_shift = 0, o_gpr_write = 0, o_gpr_addr = 0, o_busy = 0, o_done = 0, o_carry = 0, o_zero = 0.
- States:
  - IDLE → EXEC on the clock edge where i_valid && o_ready. That edge latches op, addr and imm, clears the counter, and presets the carry reg (1 for SUB, 0 otherwise).
  - EXEC lasts exactly WIDTH cycles, counter k = 0 .. WIDTH-1.
  - EXEC → DONE after the edge where k = WIDTH-1.
  - DONE lasts 1 cycle, then → IDLE.
  - Latency from accept edge to o_done is WIDTH+1 cycles. Minimum issue interval is WIDTH+2 cycles.
- EXEC outputs (all other states: o_gpr_shift = 0, o_gpr_write = 0):
  - o_gpr_shift = 1.
  - o_gpr_addr = latched addr; it holds that value in DONE and IDLE.
  - o_gpr_write = 1 for every op except CLR, where it is 0 so the GPR shifts in zeros.
- Serial ALU: a = i_gpr_bit (original bit k), b = imm[k], c = carry reg. o_gpr_data is combinational from these.
  - 000 CLR: result 0 (write disabled).
  - 001 LOAD: b.
  - 010 ADD: a^b^c; next carry = maj(a, b, c).
  - 011 SUB: a^~b^c; next carry = maj(a, ~b, c). Carry = 1 means no borrow.
  - 100 AND: a&b.
  - 101 OR: a|b.
  - 110 XOR: a^b.
  - 111 NOT: ~a (imm ignored).
  - For non-arithmetic ops the carry reg holds its preset value (0).
- Bit ordering:
  - The GPR shifts right and inserts at the MSB, so after WIDTH shifts result bit k lands at bit k.
  - Bits beyond WIDTH are discarded; ADD/SUB wrap modulo 2^WIDTH.
- Flags:
  - The zero-accumulator ORs in each result bit during EXEC.
  - On the EXEC→DONE edge: o_carry ← final carry reg, o_zero ← ~accumulator.
  - Flags are held until the next EXEC→DONE edge; an accept does not clear them.
  - CLR gives zero = 1, carry = 0.
- Handshake:
  - i_valid is ignored while o_ready = 0. No queuing, no error flag.
  - Op, addr and imm are sampled only on the accept edge; changes afterwards have no effect.
- Reset mid-operation:
  - Controller returns to IDLE immediately, with no o_done and flags cleared.
  - The GPR keeps whatever partially shifted content it holds. Software must rewrite the register.

Test Plan:
- Reset release, then LOAD addr=1 imm=0xA5 → o_ready drops the cycle after accept; 8 cycles of shift=1, write=1; o_done exactly 9 cycles after the accept edge; rx=0xA5, ry=0x00, zero=0, carry=0.
- rx=0xF0, ADD addr=1 imm=0x20 → rx=0x10, carry=1, zero=0. Then ADD imm=0x01 → rx=0x11, carry=0.
- ry=0x05, SUB addr=0 imm=0x05 → ry=0x00, carry=1, zero=1. Then SUB imm=0x01 → ry=0xFF, carry=0, zero=0.
- ry=0x3C: AND 0x0F → 0x0C; OR 0xC0 → 0xCC; XOR 0xFF → 0x33; NOT → 0xCC; CLR → 0x00 with o_gpr_write=0 throughout EXEC. rx unchanged across all of these.
- i_valid held high continuously with changing imm → accept only in IDLE, one accept every 10 cycles; each op uses the imm present at its own accept edge.
- Assert i_rst_n low at EXEC k=3 of ADD → outputs reach reset values without a clock edge; no o_done; o_ready=1 after release; next LOAD 0x5A completes correctly.
